// File: rtl/mult_ctrl_pkg.sv
// Shared state encoding, key codes and helper functions for the keypad-to-multiplier controller.
package mult_ctrl_pkg;

   typedef enum logic [2:0] {
      ENTRY_A  = 3'd0,
      ENTRY_B  = 3'd1,
      START    = 3'd2,
      WAIT_MUL = 3'd3,
      SHOW     = 3'd4
   } state_t;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

   // Used at elaboration to confirm the largest typed operand fits in W bits.
   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Decimal digit accumulator: builds a binary value from up to DIGITS typed decimal digits.
module dec_accumulator #(
   parameter int W      = 8,
   parameter int DIGITS = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load_digit,
   input  logic [3:0]   digit,
   output logic [W-1:0] value,
   output logic         full
);

   localparam int CW = $clog2(DIGITS + 1);

   logic [W-1:0]  acc_q, acc_d, acc_base, acc_times10;
   logic [CW-1:0] cnt_q, cnt_d, cnt_base;

   // A clear together with a load restarts the entry with that digit as its first one.
   // Arithmetic is kept in W bits; the W+4-bit sum truncated to W bits is the same value.
   always_comb begin
      acc_base    = clear ? '0 : acc_q;
      cnt_base    = clear ? '0 : cnt_q;
      acc_times10 = (acc_base << 3) + (acc_base << 1);
      acc_d       = acc_base;
      cnt_d       = cnt_base;
      if (load_digit && (cnt_base != CW'(DIGITS))) begin
         acc_d = acc_times10 + W'(digit);
         cnt_d = cnt_base + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign value = acc_q;
   assign full  = (cnt_q == CW'(DIGITS));

endmodule

// File: rtl/keypad_mult_ctrl.sv
// Keypad entry sequencer: two decimal operands -> multiplier start/done handshake -> held product.
// Optional WAIT_MUL timeout with error flag is enabled by defining MULT_CTRL_TIMEOUT_EN.
module keypad_mult_ctrl
   import mult_ctrl_pkg::*;
#(
   parameter int W           = 8,
   parameter int DIGITS      = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [3:0]     key_code,
   input  logic           key_valid,
   output logic           mul_start,
   output logic [W-1:0]   mul_a,
   output logic [W-1:0]   mul_b,
   input  logic           mul_done,
   input  logic [2*W-1:0] mul_product,
   output logic [2*W-1:0] result,
   output logic           result_valid,
   output logic [W-1:0]   entry_value,
   output logic           entry_sel,
   output logic           busy,
   output logic           error
);

   if (pow10(DIGITS) - 1 >= (64'd1 << W)) begin : g_bad_digits
      $error("keypad_mult_ctrl: 10^DIGITS-1 does not fit in W bits");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("keypad_mult_ctrl: TIMEOUT_CYC must be at least 1");
   end

   state_t         state_q, state_d;
   logic           key_valid_q, key_valid_d;
   logic [W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [2*W-1:0] result_q, result_d;
   logic           entry_sel_q, entry_sel_d;
   logic           has_digit_q, has_digit_d;
   logic           acc_clear, acc_load, acc_full;
   logic [W-1:0]   acc_value;
   logic           key_accept, is_clear, is_enter, is_dig, timeout_hit;

   assign key_accept = key_valid && !key_valid_q;
   assign is_clear   = key_accept && (key_code == KEY_CLEAR);
   assign is_enter   = key_accept && (key_code == KEY_ENTER);
   assign is_dig     = key_accept && is_digit(key_code);

`ifdef MULT_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          error_q, error_d;

   assign timeout_hit = (state_q == WAIT_MUL) && !mul_done && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

   // A CLEAR beats a simultaneous timeout; any other accepted key acknowledges the error.
   always_comb begin
      tmo_cnt_d = (state_q == WAIT_MUL) ? tmo_cnt_q + TW'(1) : '0;
      error_d   = error_q;
      if (is_clear)         error_d = 1'b0;
      else if (timeout_hit) error_d = 1'b1;
      else if (key_accept)  error_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         error_q   <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         error_q   <= error_d;
      end
   end

   assign error = error_q;
`else
   assign timeout_hit = 1'b0;
   assign error       = 1'b0;
`endif

   dec_accumulator #(.W(W), .DIGITS(DIGITS)) u_acc (
      .clk        (clk),
      .reset      (reset),
      .clear      (acc_clear),
      .load_digit (acc_load),
      .digit      (key_code),
      .value      (acc_value),
      .full       (acc_full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ENTRY_A;
         key_valid_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         result_q    <= '0;
         entry_sel_q <= 1'b0;
         has_digit_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_valid_q <= key_valid_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         result_q    <= result_d;
         entry_sel_q <= entry_sel_d;
         has_digit_q <= has_digit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (is_clear || timeout_hit) begin
         state_d = ENTRY_A;
      end else begin
         case (state_q)
            ENTRY_A:  if (is_enter && has_digit_q) state_d = ENTRY_B;
            ENTRY_B:  if (is_enter && has_digit_q) state_d = START;
            START:    state_d = WAIT_MUL;
            WAIT_MUL: if (mul_done) state_d = SHOW;
            SHOW:     if (is_dig) state_d = ENTRY_A;
            default:  state_d = ENTRY_A;
         endcase
      end
   end

   // Operand, result and accumulator control; a digit typed in SHOW starts operand A afresh.
   always_comb begin
      key_valid_d = key_valid;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      result_d    = result_q;
      entry_sel_d = entry_sel_q;
      has_digit_d = has_digit_q;
      acc_clear   = 1'b0;
      acc_load    = 1'b0;
      if (is_clear || timeout_hit) begin
         mul_a_d     = '0;
         mul_b_d     = '0;
         result_d    = '0;
         entry_sel_d = 1'b0;
         has_digit_d = 1'b0;
         acc_clear   = 1'b1;
      end else begin
         case (state_q)
            ENTRY_A, ENTRY_B: begin
               if (is_dig) begin
                  acc_load    = !acc_full;
                  has_digit_d = 1'b1;
               end else if (is_enter && has_digit_q) begin
                  if (state_q == ENTRY_A) begin
                     mul_a_d     = acc_value;
                     entry_sel_d = 1'b1;
                     has_digit_d = 1'b0;
                     acc_clear   = 1'b1;
                  end else begin
                     mul_b_d = acc_value;
                  end
               end
            end
            WAIT_MUL: if (mul_done) result_d = mul_product;
            SHOW: begin
               if (is_dig) begin
                  result_d    = '0;
                  entry_sel_d = 1'b0;
                  has_digit_d = 1'b1;
                  acc_clear   = 1'b1;
                  acc_load    = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mul_start    = (state_q == START);
      busy         = (state_q == START) || (state_q == WAIT_MUL);
      result_valid = (state_q == SHOW);
   end

   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign result      = result_q;
   assign entry_value = acc_value;
   assign entry_sel   = entry_sel_q;

endmodule

// File: doc/keypad_mult_ctrl.md
Name: keypad_mult_ctrl

Overview:
- Sequences keypad entry into the multiplier datapath.
- Consumes debounced 4-bit key codes with a level-valid flag from the debouncer.
- Assembles two decimal operands digit by digit, converts them to binary, issues a start pulse to the multiplier, waits for done, and holds the product for display.
- Sits between the keypad debouncer and the multiplier core.

Parameters:
- W, default 8: operand width in bits. Product width is 2*W.
- DIGITS, default 2: maximum decimal digits per operand. Elaboration must fail unless 10^DIGITS-1 < 2^W.
- TIMEOUT_CYC, default 1024: cycles allowed in WAIT_MUL. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_code  in  4  debounced key code
- key_valid  in  1  level; high while key_code is stable
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_a  out  W  operand A, binary
- mul_b  out  W  operand B, binary
- mul_done  in  1  multiplier completion pulse; product is valid in the same cycle
- mul_product  in  2W  multiplier result
- result  out  2W  latched product
- result_valid  out  1  high while in SHOW
- entry_value  out  W  operand currently being typed, binary
- entry_sel  out  1  0 = entering A, 1 = entering B
- busy  out  1  high in START and WAIT_MUL
- error  out  1  timeout flag; constant 0 without the optional feature

Behaviour:
- Reset (asynchronous, active-high): state=ENTRY_A. All outputs and registers are 0, including digit counter and key_valid delay register.
- Key accept: a key is accepted only on a key_valid rising edge (key_valid=1 and last-cycle key_valid=0). Exactly one accept per press. A held key never repeats.
- Key codes: 0x0-0x9 are digits, 0xA is ENTER, 0xB is CLEAR. 0xC-0xF are ignored in every state.
- Digit accept: acc <= acc*10 + digit, computed as (acc<<3)+(acc<<1)+digit in W+4 bits and truncated to W. Digit counter increments. Once counter == DIGITS, further digits are ignored and acc is unchanged.
- entry_value shows acc. It updates in the cycle after the accepting edge.
- ENTRY_A:
  - digit: accumulate.
  - ENTER with counter>0: mul_a <= acc, acc/counter cleared, go to ENTRY_B, entry_sel=1.
  - ENTER with counter=0: ignored.
- ENTRY_B:
  - digit: accumulate.
  - ENTER with counter>0: mul_b <= acc, go to START.
  - ENTER with counter=0: ignored.
- START: mul_start=1 for exactly one cycle, then go to WAIT_MUL. Latency from accepted ENTER to mul_start is 1 cycle.
- WAIT_MUL:
  - all keys except CLEAR are ignored.
  - mul_done=1: result <= mul_product, go to SHOW.
  - mul_done during any other state is ignored.
- SHOW:
  - result_valid=1; result is held.
  - a digit clears result and result_valid, enters ENTRY_A, and that same digit becomes the first digit of A (acc=digit, counter=1).
  - ENTER is ignored.
- CLEAR in any state:
  - go to ENTRY_A next cycle; acc, counter, mul_a, mul_b, result, result_valid, error and entry_sel are cleared.
  - In WAIT_MUL, a mul_done arriving in the CLEAR cycle or later is discarded.
- Simultaneous CLEAR edge and mul_done in WAIT_MUL: CLEAR wins.
- mul_a and mul_b stay stable from START until the next CLEAR or new entry completion.

Optional Feature:
- Macro: MULT_CTRL_TIMEOUT_EN.
- Defined:
  - a counter runs in WAIT_MUL. After TIMEOUT_CYC cycles without mul_done, set error=1 and go to ENTRY_A with registers cleared except error.
  - error clears on the next accepted key.
- Undefined: no counter; error tied to 0; WAIT_MUL waits indefinitely.

Decomposition:
- Package mult_ctrl_pkg:
  - state enum: ENTRY_A, ENTRY_B, START, WAIT_MUL, SHOW.
  - key constants: KEY_ENTER=4'hA, KEY_CLEAR=4'hB.
  - function is_digit().
- One sub-module, dec_accumulator: owns acc, the digit counter, and the x10 multiply-add. Inputs are clear, load_digit and digit; outputs are value and full.

Test Plan:
- Keys 1,2,ENTER,3,4,ENTER (each held 5 cycles with valid high) -> mul_a=12, mul_b=34, one mul_start pulse. Model returns done with 408 -> result=408, result_valid=1.
- Key 7 held valid for 50 cycles -> entry_value=7 and counter=1; no repeat accept.
- Keys 9,9,9,ENTER -> third digit ignored, mul_a=99. ENTER with no digits in ENTRY_B -> stays in ENTRY_B.
- CLEAR during WAIT_MUL, then mul_done with 500 two cycles later -> state ENTRY_A, result=0, result_valid=0.
- From SHOW (result=408), key 5 -> result_valid=0, entry_sel=0, entry_value=5. Reset mid-WAIT_MUL -> all outputs 0 immediately, without waiting for a clock edge.
- MULT_CTRL_TIMEOUT_EN, TIMEOUT_CYC=16, no mul_done -> error=1 on cycle 16 of WAIT_MUL, state ENTRY_A. Next accepted key clears error.
